// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: FSM states, pipeline slot record, x0 constant.
// Register indices are held at MAX_REG_W bits inside slots; REG_W must not exceed it.
package hazard_pkg;

  localparam int MAX_REG_W = 8;

  typedef logic [MAX_REG_W-1:0] slot_rd_t;

  localparam slot_rd_t REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } hazard_state_t;

  typedef struct packed {
    slot_rd_t rd;
    logic     wen;
    logic     load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  function automatic logic is_producer(input slot_t s);
    return s.wen && (s.rd != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Matches one pipeline slot against the two decode source operands.
// An x0 destination, a non-writing slot or an unread source never matches.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  slot_t            slot,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use1,
  input  logic             use2,
  output logic             hit1,
  output logic             hit2
);

  logic producer;

  assign producer = is_producer(slot);
  assign hit1     = producer && use1 && (slot.rd == slot_rd_t'(rs1));
  assign hit2     = producer && use2 && (slot.rd == slot_rd_t'(rs2));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush, memory wait.
// Build option HAZARD_FRWD_MEM_EN enables forwarding from the MEM slot; otherwise MEM hits stall.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_id_reg_wen,
  input  logic             i_id_mem_reg,
  input  logic             i_branch_taken,
  input  logic             i_mem_busy,
  output logic             o_frwd_alu_op1,
  output logic             o_frwd_mem_op1,
  output logic             o_frwd_alu_op2,
  output logic             o_frwd_mem_op2,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic [CNT_W-1:0] o_stall_cnt,
  output hazard_state_t    o_state
);

  slot_t         ex_slot, mem_slot, ex_next;
  hazard_state_t state;
  logic          ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic          load_use, mem_stall, data_stall, flush, stall, issue;
  logic          alu1, alu2, mem1, mem2;
  logic [CNT_W-1:0] stall_cnt;

  hazard_cmp #(.REG_W(REG_W)) u_cmp_ex (
    .slot(ex_slot), .rs1(i_id_rs1), .rs2(i_id_rs2),
    .use1(i_id_use_rs1), .use2(i_id_use_rs2), .hit1(ex_hit1), .hit2(ex_hit2)
  );

  hazard_cmp #(.REG_W(REG_W)) u_cmp_mem (
    .slot(mem_slot), .rs1(i_id_rs1), .rs2(i_id_rs2),
    .use1(i_id_use_rs1), .use2(i_id_use_rs2), .hit1(mem_hit1), .hit2(mem_hit2)
  );

  assign load_use = i_id_valid && ex_slot.load && (ex_hit1 || ex_hit2);

`ifdef HAZARD_FRWD_MEM_EN
  assign mem_stall = 1'b0;
`else
  // A MEM hit only matters when EX does not hold a younger write of the same register.
  assign mem_stall = i_id_valid && ((mem_hit1 && !ex_hit1) || (mem_hit2 && !ex_hit2));
`endif

  assign data_stall = load_use || mem_stall;
  assign flush      = !i_rst && !i_mem_busy && i_branch_taken;
  assign stall      = !i_rst && (i_mem_busy || (!i_branch_taken && data_stall));
  assign issue      = !i_rst && !i_mem_busy && !i_branch_taken && !data_stall && i_id_valid;

  assign o_stall_if  = stall;
  assign o_stall_id  = stall;
  assign o_bubble_ex = !i_rst && !i_mem_busy && !i_branch_taken && data_stall;
  assign o_flush_if  = flush;
  assign o_flush_id  = flush;

  always_comb begin
    ex_next = SLOT_BUBBLE;
    if (issue) begin
      ex_next.rd   = slot_rd_t'(i_id_rd);
      ex_next.wen  = i_id_reg_wen;
      ex_next.load = i_id_mem_reg;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_slot   <= SLOT_BUBBLE;
      mem_slot  <= SLOT_BUBBLE;
      alu1      <= 1'b0;
      alu2      <= 1'b0;
      mem1      <= 1'b0;
      mem2      <= 1'b0;
      stall_cnt <= '0;
      state     <= ST_RUN;
    end else if (i_mem_busy) begin
      // Pipeline frozen: slots and selects hold, only the stall counter moves.
      state <= ST_MEM_WAIT;
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      mem_slot <= ex_slot;
      ex_slot  <= ex_next;
      alu1     <= issue && ex_hit1;
      alu2     <= issue && ex_hit2;
`ifdef HAZARD_FRWD_MEM_EN
      mem1     <= issue && mem_hit1 && !ex_hit1;
      mem2     <= issue && mem_hit2 && !ex_hit2;
`else
      mem1     <= 1'b0;
      mem2     <= 1'b0;
`endif
      state    <= (data_stall && !i_branch_taken) ? ST_LOAD_STALL : ST_RUN;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign o_frwd_alu_op1 = alu1;
  assign o_frwd_alu_op2 = alu2;
  assign o_frwd_mem_op1 = mem1;
  assign o_frwd_mem_op2 = mem2;
  assign o_stall_cnt    = stall_cnt;
  assign o_state        = state;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed hazard scenarios then random traffic,
// checked against an instruction-history reference model.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FRWD_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  // clock / reset and DUT signals
  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_id_valid = 1'b0;
  logic [REG_W-1:0] i_id_rs1 = '0, i_id_rs2 = '0, i_id_rd = '0;
  logic             i_id_use_rs1 = 1'b0, i_id_use_rs2 = 1'b0;
  logic             i_id_reg_wen = 1'b0, i_id_mem_reg = 1'b0;
  logic             i_branch_taken = 1'b0, i_mem_busy = 1'b0;
  logic             o_frwd_alu_op1, o_frwd_mem_op1, o_frwd_alu_op2, o_frwd_mem_op2;
  logic             o_stall_if, o_stall_id, o_bubble_ex, o_flush_if, o_flush_id;
  logic [CNT_W-1:0] o_stall_cnt;
  hazard_state_t    o_state;

  always #5 i_clk = ~i_clk;

  hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_id_rd(i_id_rd), .i_id_reg_wen(i_id_reg_wen), .i_id_mem_reg(i_id_mem_reg),
    .i_branch_taken(i_branch_taken), .i_mem_busy(i_mem_busy),
    .o_frwd_alu_op1(o_frwd_alu_op1), .o_frwd_mem_op1(o_frwd_mem_op1),
    .o_frwd_alu_op2(o_frwd_alu_op2), .o_frwd_mem_op2(o_frwd_mem_op2),
    .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_bubble_ex(o_bubble_ex),
    .o_flush_if(o_flush_if), .o_flush_id(o_flush_id),
    .o_stall_cnt(o_stall_cnt), .o_state(o_state)
  );

  // reference model: hist[0] = instruction now in EX, hist[1] = now in MEM
  typedef struct {
    int rd;
    bit wen;
    bit load;
  } instr_t;

  instr_t        hist[$];
  bit            m_alu[2], m_mem[2];
  int            m_cnt;
  hazard_state_t m_state;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.rd = 0; b.wen = 1'b0; b.load = 1'b0;
    return b;
  endfunction

  // age of the youngest in-flight writer of rs, -1 if none (x0 never has one)
  function automatic int producer_age(input int rs);
    if (rs == 0) return -1;
    for (int a = 0; a < 2; a++)
      if (hist[a].wen && hist[a].rd == rs) return a;
    return -1;
  endfunction

  // one clock: drive at posedge+1, check combinational outputs mid-cycle,
  // advance model, check registered outputs at next posedge+1
  task automatic step(input bit rst, input bit valid, input int rs1, input int rs2,
                      input bit u1, input bit u2, input int rd, input bit wen,
                      input bit ld, input bit br, input bit busy, output bit issued);
    int rs[2];
    bit u[2];
    bit hazard, e_stall, e_bubble, e_flush;
    int age;
    instr_t ni;
    rs[0] = rs1; rs[1] = rs2; u[0] = u1; u[1] = u2;
    i_rst = rst; i_id_valid = valid;
    i_id_rs1 = REG_W'(rs1); i_id_rs2 = REG_W'(rs2);
    i_id_use_rs1 = u1; i_id_use_rs2 = u2;
    i_id_rd = REG_W'(rd); i_id_reg_wen = wen; i_id_mem_reg = ld;
    i_branch_taken = br; i_mem_busy = busy;

    hazard = 1'b0;
    if (valid)
      for (int op = 0; op < 2; op++)
        if (u[op]) begin
          age = producer_age(rs[op]);
          if (age == 0 && hist[0].load) hazard = 1'b1;
          if (age == 1 && !MEM_EN) hazard = 1'b1;
        end
    e_flush  = !rst && !busy && br;
    e_stall  = !rst && (busy || (!br && hazard));
    e_bubble = !rst && !busy && !br && hazard;
    issued   = !rst && !busy && !br && valid && !hazard;

    #4;
    check("stall_if", o_stall_if, e_stall);
    check("stall_id", o_stall_id, e_stall);
    check("bubble_ex", o_bubble_ex, e_bubble);
    check("flush_if", o_flush_if, e_flush);
    check("flush_id", o_flush_id, e_flush);

    if (rst) begin
      hist.delete();
      hist.push_back(bubble());
      hist.push_back(bubble());
      m_alu = '{0, 0}; m_mem = '{0, 0};
      m_cnt = 0; m_state = ST_RUN;
    end else if (busy) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      m_state = ST_MEM_WAIT;
    end else begin
      for (int op = 0; op < 2; op++) begin
        m_alu[op] = 1'b0; m_mem[op] = 1'b0;
        if (issued && u[op]) begin
          age = producer_age(rs[op]);
          m_alu[op] = (age == 0);
          m_mem[op] = (age == 1) && MEM_EN;
        end
      end
      ni = bubble();
      if (issued) begin ni.rd = rd; ni.wen = wen; ni.load = ld; end
      hist.push_front(ni);
      void'(hist.pop_back());
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      m_state = e_bubble ? ST_LOAD_STALL : ST_RUN;
    end

    @(posedge i_clk); #1;
    check("frwd_alu_op1", o_frwd_alu_op1, m_alu[0]);
    check("frwd_alu_op2", o_frwd_alu_op2, m_alu[1]);
    check("frwd_mem_op1", o_frwd_mem_op1, m_mem[0]);
    check("frwd_mem_op2", o_frwd_mem_op2, m_mem[1]);
    check("stall_cnt", o_stall_cnt, m_cnt);
    check("state", o_state, m_state);
  endtask

  task automatic idle();
    bit iss;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, iss);
  endtask

  task automatic reset_dut();
    bit iss;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, iss);
  endtask

  // hold an instruction in decode until it issues, bounded
  task automatic issue(input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit wen, input bit ld);
    bit iss;
    int tries;
    iss = 1'b0;
    tries = 0;
    while (!iss && tries < 6) begin
      step(0, 1, rs1, rs2, u1, u2, rd, wen, ld, 0, 0, iss);
      tries++;
    end
    check("issue_within_bound", iss, 1'b1);
  endtask

  initial begin
    bit iss;
    int c0;
    hist.push_back(bubble());
    hist.push_back(bubble());
    m_cnt = 0; m_state = ST_RUN;
    @(posedge i_clk); #1;

    reset_dut();
    reset_dut();
    check("reset_cnt", o_stall_cnt, 0);

    // add x5 ; add x6,x5,x7 -> alu forward on op1
    issue(1, 2, 1, 1, 5, 1, 0);
    issue(5, 7, 1, 1, 6, 1, 0);
    check("alu_fwd_op1", o_frwd_alu_op1, 1);
    check("alu_fwd_op2", o_frwd_alu_op2, 0);
    idle(); idle();

    // lw x5 ; add x6,x7,x5 -> load-use stall, then MEM forward or second stall
    reset_dut();
    issue(1, 0, 1, 0, 5, 1, 1);
    issue(7, 5, 1, 1, 6, 1, 0);
    check("load_use_cnt", o_stall_cnt, MEM_EN ? 1 : 2);
    check("load_use_mem_op2", o_frwd_mem_op2, MEM_EN);
    idle(); idle();

    // addi x0 ; add x6,x0,x0 -> nothing forwarded
    issue(1, 0, 1, 0, 0, 1, 0);
    issue(0, 0, 1, 1, 6, 1, 0);
    idle(); idle();

    // lw x5 then dependent with branch taken -> flush wins over stall
    issue(1, 0, 1, 0, 5, 1, 1);
    c0 = int'(o_stall_cnt);
    step(0, 1, 5, 5, 1, 1, 6, 1, 0, 1, 0, iss);
    check("flush_no_stall_cnt", int'(o_stall_cnt) - c0, 0);
    idle(); idle();

    // add x5 ; dependent held by 3 busy cycles, then forwarded
    issue(1, 0, 1, 0, 5, 1, 0);
    c0 = int'(o_stall_cnt);
    for (int k = 0; k < 3; k++) step(0, 1, 5, 3, 1, 1, 6, 1, 0, k == 1, 1, iss);
    check("busy_cnt_delta", int'(o_stall_cnt) - c0, 3);
    issue(5, 3, 1, 1, 6, 1, 0);
    check("after_busy_alu_op1", o_frwd_alu_op1, 1);
    idle(); idle();

    // busy arriving while a forward select is live keeps it held
    issue(1, 0, 1, 0, 4, 1, 0);
    issue(2, 4, 1, 1, 9, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, iss);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, iss);
    check("busy_hold_alu_op2", o_frwd_alu_op2, 1);
    idle(); idle();

    // random traffic over a small register set to provoke hazards
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, iss);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
